// File: rtl/i2s_receiver.sv
// I2S receiver: deserialises left/right slots and presents each completed pair on a valid/ready output.
// Define I2S_RX_FRAME_ERR_EN to add slot-length checking and the frame_err port.
module i2s_receiver #(
    parameter int SLOT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lr_clk,
    input  logic                 sd_in,
    output logic [SLOT_BITS-1:0] left_data,
    output logic [SLOT_BITS-1:0] right_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    localparam int               CNT_W    = $clog2(SLOT_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        UNSYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t state;
    state_t state_next;

    logic                 lr_d;
    logic                 lr_edge;
    // Only the low SLOT_BITS-1 history bits can ever reach a completed word.
    logic [SLOT_BITS-2:0] shreg;
    logic [SLOT_BITS-1:0] word;
    logic [SLOT_BITS-1:0] left_hold;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 capture_left;
    logic                 pair_done;
    logic                 pair_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    assign lr_edge = (lr_clk != lr_d);
    assign word    = {shreg, sd_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNSYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        capture_left = 1'b0;
        pair_done    = 1'b0;
        if (lr_edge) begin
            case (state)
                UNSYNC: begin
                    if (!lr_clk) begin
                        state_next = LEFT;
                    end
                end
                LEFT: begin
                    capture_left = 1'b1;
                    state_next   = RIGHT;
                end
                RIGHT: begin
                    pair_done  = 1'b1;
                    state_next = LEFT;
                end
                default: state_next = UNSYNC;
            endcase
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic slot_err;
    logic left_bad;

    assign slot_err = (capture_left || pair_done) && (bit_cnt != CNT_FULL);
    assign pair_ok  = pair_done && !left_bad && !slot_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            left_bad  <= 1'b0;
        end else begin
            frame_err <= slot_err;
            if (capture_left) begin
                left_bad <= slot_err;
            end
        end
    end
`else
    assign pair_ok = pair_done;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lr_d       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            left_hold  <= '0;
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            lr_d    <= lr_clk;
            shreg   <= word[SLOT_BITS-2:0];
            bit_cnt <= lr_edge ? CNT_W'(1) : sat_inc(bit_cnt);
            overrun <= 1'b0;
            if (capture_left) begin
                left_hold <= word;
            end
            // A landing pair wins over a same-cycle consume; overrun only if nobody took the old one.
            if (pair_ok) begin
                left_data  <= left_hold;
                right_data <= word;
                out_valid  <= 1'b1;
                overrun    <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
